// File: rtl/spi_slave_tx.sv
// SPI mode-1 slave transmitter: oversamples sck/cs in the clk domain and shifts a
// byte out on miso MSB first, fed from a single-entry holding register.
//   state   | meaning
//   ST_IDLE | cs high, pad released, waiting for cs_fall
//   ST_SHIFT| frame active, shifting bytes on sck rises
module spi_slave_tx #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       cs,
  input  logic [7:0] data,
  input  logic       load,
  output logic       ready,
  output logic       miso,
  output logic       miso_oe,
  output logic       done,
  output logic       underrun
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [7:0] sreg_q, sreg_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       miso_q, miso_d;
  logic       miso_oe_q, miso_oe_d;
  logic       done_q, done_d;
  logic       underrun_q, underrun_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic reload;

  // [0],[1] synchronise; [2] is the previous value for edge detection
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];

  always_comb begin
    state_d      = state_q;
    sck_sync_d   = {sck_sync_q[1:0], sck};
    cs_sync_d    = {cs_sync_q[1:0], cs};
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    reload       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        bit_cnt_d = 4'd0;
        if (cs_fall) begin
          reload    = 1'b1;
          miso_oe_d = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
          bit_cnt_d = 4'd0;
        end else if (sck_rise) begin
          miso_d = sreg_q[7];
          sreg_d = {sreg_q[6:0], 1'b0};
          if (bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (sck_fall && (bit_cnt_q == 4'd8)) begin
          done_d    = 1'b1;
          bit_cnt_d = 4'd0;
          reload    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A reload drains hold first, so a same-cycle load refills it rather than being dropped
    if (reload) begin
      if (hold_valid_q) begin
        sreg_d = hold_q;
        if (load) begin
          hold_d = data;
        end else begin
          hold_valid_d = 1'b0;
        end
      end else if (load) begin
        sreg_d = data;
      end else begin
        sreg_d     = IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end else if (load && !hold_valid_q) begin
      hold_d       = data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sck_sync_q   <= 3'b000;
      cs_sync_q    <= 3'b111;
      sreg_q       <= 8'h00;
      bit_cnt_q    <= 4'd0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= sck_sync_d;
      cs_sync_q    <= cs_sync_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign ready    = ~hold_valid_q;
  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: acts as a mode-1 SPI master at clk/8, predicts received
// bytes with a byte-level holding-register model, and scores them as done pulses appear.
module tb_spi_slave_tx;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  logic       clk = 1'b0;
  logic       reset, sck, cs, load;
  logic [7:0] data;
  logic       ready, miso, miso_oe, done, underrun;

  spi_slave_tx #(.IDLE_BYTE(IDLE_BYTE)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .data(data), .load(load),
    .ready(ready), .miso(miso), .miso_oe(miso_oe), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0, under_cnt = 0;
  int exp_done = 0, exp_under = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_shift = 8'h00;

  // reference model of the holding register
  logic       m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // master samples miso on sck fall
  always @(negedge sck) if (!cs && !reset) rx_shift = {rx_shift[6:0], miso};

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_byte: got %0h with no byte expected", rx_shift);
        end else begin
          check("rx_byte", rx_shift, exp_q.pop_front());
        end
      end
      if (underrun) under_cnt++;
    end
  end

  task automatic model_load(input logic [7:0] d);
    if (!m_full) begin
      m_hold = d;
      m_full = 1'b1;
    end
  endtask

  // byte-start event: what goes out next, and whether it will be fully shifted
  task automatic model_reload(input bit ld, input logic [7:0] d, input bit push);
    logic [7:0] b;
    if (m_full) begin
      b = m_hold;
      if (ld) m_hold = d;
      else m_full = 1'b0;
    end else if (ld) begin
      b = d;
    end else begin
      b = IDLE_BYTE;
      exp_under++;
    end
    if (push) begin
      exp_q.push_back(b);
      exp_done++;
    end
  endtask

  task automatic do_load(input logic [7:0] d);
    load = 1'b1;
    data = d;
    model_load(d);
    @(negedge clk);
    load = 1'b0;
  endtask

  // called at the negedge where cs fell or sck made its 8th fall; the DUT reloads two cycles later
  task automatic reload_phase(input bit ld, input logic [7:0] d, input bit push, input bit is_cs);
    @(negedge clk);
    @(negedge clk);
    if (is_cs) check("oe_before", miso_oe, 1'b0);
    if (ld) begin
      load = 1'b1;
      data = d;
    end
    model_reload(ld, d, push);
    @(negedge clk);
    load = 1'b0;
    if (is_cs) check("oe_after", miso_oe, 1'b1);
    check("ready_reload", ready, !m_full);
  endtask

  task automatic run_frame(input int nbytes, input int abort_rises, input bit start_ld,
                           input logic [7:0] start_d, input logic [3:0] mid_en,
                           input logic [31:0] mid_d);
    int total;
    int nbits;
    total = nbytes + ((abort_rises > 0) ? 1 : 0);
    cs = 1'b0;
    reload_phase(start_ld, start_d, nbytes > 0, 1'b1);
    repeat (3) @(negedge clk);
    for (int b = 0; b < total; b++) begin
      nbits = (b < nbytes) ? 8 : abort_rises;
      for (int i = 0; i < nbits; i++) begin
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
        if (i == 5) check("ready_mid", ready, !m_full);
        if (i == 7) begin
          reload_phase(1'b0, 8'h00, (b + 1) < nbytes, 1'b0);
          @(negedge clk);
        end else if (i == 2 && b < 4 && mid_en[b]) begin
          do_load(mid_d[b*8 +: 8]);
          repeat (3) @(negedge clk);
        end else begin
          repeat (4) @(negedge clk);
        end
      end
    end
    cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("oe_hold", miso_oe, 1'b1);
    @(negedge clk);
    check("oe_release", miso_oe, 1'b0);
    check("miso_idle", miso, 1'b0);
    repeat (4) @(negedge clk);
    check("done_count", done_cnt, exp_done);
    check("underrun_count", under_cnt, exp_under);
    check("pending_bytes", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int nb, ab;
    logic [7:0] r;
    reset = 1'b1;
    sck   = 1'b0;
    cs    = 1'b1;
    load  = 1'b0;
    data  = 8'h00;
    pulses = 0;

    // reset with bus activity
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sck = ~sck;
      if (i % 3 == 0) cs = ~cs;
      if (i > 1) pulses += int'(done) + int'(underrun);
    end
    @(negedge clk);
    sck = 1'b0;
    cs  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_pulses", pulses, 0);
    check("rst_miso", miso, 1'b0);
    check("rst_oe", miso_oe, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_oe", miso_oe, 1'b0);

    // single byte
    do_load(8'hA5);
    repeat (2) @(negedge clk);
    check("ready_full", ready, 1'b0);
    run_frame(1, 0, 1'b0, 8'h00, 4'b0000, 32'h0);

    // underrun
    run_frame(1, 0, 1'b0, 8'h00, 4'b0000, 32'h0);

    // multi-byte, third load keeps the end-of-frame reload fed
    do_load(8'h55);
    run_frame(2, 0, 1'b0, 8'h00, 4'b0011, 32'h0000_7723);

    // abort after 4 rises, then a clean frame
    do_load(8'hFF);
    run_frame(0, 4, 1'b0, 8'h00, 4'b0000, 32'h0);
    do_load(8'h0F);
    run_frame(1, 0, 1'b0, 8'h00, 4'b0000, 32'h0);

    // second load while full is ignored
    do_load(8'h11);
    do_load(8'h22);
    repeat (2) @(negedge clk);
    check("ready_ignored", ready, 1'b0);
    run_frame(1, 0, 1'b0, 8'h00, 4'b0000, 32'h0);

    // bypass: load coincides with reload while hold empty
    run_frame(1, 0, 1'b1, 8'h3C, 4'b0000, 32'h0);

    // reload consumes hold while a same-cycle load refills it
    do_load(8'h9A);
    run_frame(2, 0, 1'b1, 8'h4B, 4'b0000, 32'h0);

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(1, 0) == 1) do_load(8'($urandom));
      if ($urandom_range(3, 0) == 0) do_load(8'($urandom));
      repeat (2) @(negedge clk);
      check("ready_pre", ready, !m_full);
      nb = $urandom_range(3, 1);
      ab = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
      if (ab > 0 && $urandom_range(1, 0) == 1) nb = 0;
      r = 8'($urandom);
      run_frame(nb, ab, $urandom_range(4, 0) == 0, r, 4'($urandom), $urandom);
    end

    check("final_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
